// File: rtl/light_pkg.sv
// ============================================================================
// Module      : light_pkg
// Description : Types and constants shared by the timebase and light controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_pkg;

   typedef enum logic [1:0] {
      S_LO   = 2'd0,
      S_RISE = 2'd1,
      S_HI   = 2'd2,
      S_FALL = 2'd3
   } deb_state_t;

   localparam int SEC_W      = 6;
   localparam int DEF_CLK_HZ = 24_000_000;

endpackage

`default_nettype wire

// File: rtl/light_timebase_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer plus counting debounce FSM for a button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
   import light_pkg::*;
#(
   parameter int DEB_CYCLES = 480_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean
);

   localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             sample;

   assign sample = sync_q[1];
   assign clean  = clean_q;

   // The entry edge counts as the first stable sample, so the window closes
   // on the edge where the count would reach DEB_CYCLES.
   always_comb begin
      sync_d  = {sync_q[0], raw};
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      unique case (state_q)
         S_LO: begin
            if (sample) begin
               state_d = S_RISE;
               cnt_d   = CNT_ONE;
            end
         end
         S_RISE: begin
            if (!sample) begin
               state_d = S_LO;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = S_HI;
               cnt_d   = '0;
               clean_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HI: begin
            if (!sample) begin
               state_d = S_FALL;
               cnt_d   = CNT_ONE;
            end
         end
         S_FALL: begin
            if (sample) begin
               state_d = S_HI;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = S_LO;
               cnt_d   = '0;
               clean_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_LO;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= S_LO;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/light_timebase.sv
// ============================================================================
// Module      : light_timebase
// Description : 1 s tick, 0..59 seconds count and latched pedestrian request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_timebase
   import light_pkg::*;
#(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int SEC_WRAP   = 60,
   parameter int DEB_CYCLES = 480_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sync_clr,
   input  logic             btn_raw,
   input  logic             req_ack,
   output logic             tick_1s,
   output logic [SEC_W-1:0] saniye,
   output logic             minute_wrap,
   output logic             btn_clean,
   output logic             ped_req
);

   localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_WRAP - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             clean_prev_q, clean_prev_d;
   logic             ped_req_q, ped_req_d;
   logic             clean_w;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw),
      .clean (clean_w)
   );

   always_comb begin
      pre_d  = pre_q;
      sec_d  = sec_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (sync_clr) begin
         pre_d = '0;
         sec_d = '0;
      end else if (enable) begin
         if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (sec_q == SEC_LAST) begin
               sec_d  = '0;
               wrap_d = 1'b1;
            end else begin
               sec_d = sec_q + SEC_W'(1);
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // A fresh press outranks a simultaneous ack so the press is never dropped.
   always_comb begin
      clean_prev_d = clean_w;
      ped_req_d    = ped_req_q;
      if (clean_w && !clean_prev_q) begin
         ped_req_d = 1'b1;
      end else if (req_ack) begin
         ped_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q        <= '0;
         sec_q        <= '0;
         tick_q       <= 1'b0;
         wrap_q       <= 1'b0;
         clean_prev_q <= 1'b0;
         ped_req_q    <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         sec_q        <= sec_d;
         tick_q       <= tick_d;
         wrap_q       <= wrap_d;
         clean_prev_q <= clean_prev_d;
         ped_req_q    <= ped_req_d;
      end
   end

   assign tick_1s     = tick_q;
   assign saniye      = sec_q;
   assign minute_wrap = wrap_q;
   assign btn_clean   = clean_w;
   assign ped_req     = ped_req_q;

endmodule

`default_nettype wire

// File: tb/tb_light_timebase.sv
// ============================================================================
// Module      : tb_light_timebase
// Description : Directed self-checking bench for light_timebase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_timebase;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       sync_clr;
   logic       btn_raw;
   logic       req_ack;
   logic       tick_1s;
   logic [5:0] saniye;
   logic       minute_wrap;
   logic       btn_clean;
   logic       ped_req;

   int total = 0;
   int bad   = 0;

   light_timebase #(
      .CLK_HZ     (10),
      .SEC_WRAP   (60),
      .DEB_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sync_clr    (sync_clr),
      .btn_raw     (btn_raw),
      .req_ack     (req_ack),
      .tick_1s     (tick_1s),
      .saniye      (saniye),
      .minute_wrap (minute_wrap),
      .btn_clean   (btn_clean),
      .ped_req     (ped_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      enable   = 1'b1;
      sync_clr = 1'b0;
      btn_raw  = 1'b0;
      req_ack  = 1'b0;

      #3;
      chk("rst_tick",  tick_1s,     0);
      chk("rst_sec",   saniye,      0);
      chk("rst_wrap",  minute_wrap, 0);
      chk("rst_clean", btn_clean,   0);
      chk("rst_req",   ped_req,     0);

      @(posedge clk); #1;
      reset = 1'b1;

      // Ticks at enabled edges 10, 20, 30.
      edges(9);
      chk("pre_tick1", tick_1s, 0);
      edges(1);
      chk("tick1",     tick_1s, 1);
      chk("sec1",      saniye,  1);
      edges(1);
      chk("tick1_end", tick_1s, 0);
      edges(9);
      chk("tick2",     tick_1s, 1);
      chk("sec2",      saniye,  2);
      edges(10);
      chk("tick3",     tick_1s, 1);
      chk("sec3",      saniye,  3);

      // Minute wrap at edge 600.
      edges(560);
      chk("sec59",     saniye,      59);
      chk("wrap59",    minute_wrap, 0);
      edges(10);
      chk("tick600",   tick_1s,     1);
      chk("sec600",    saniye,      0);
      chk("wrap600",   minute_wrap, 1);
      edges(1);
      chk("wrap_end",  minute_wrap, 0);

      // Freeze at prescaler=4 for 5 edges; tick slips from 610 to 615.
      edges(3);
      enable = 1'b0;
      edges(5);
      chk("frz_tick",  tick_1s, 0);
      chk("frz_sec",   saniye,  0);
      enable = 1'b1;
      edges(5);
      chk("late_none", tick_1s, 0);
      chk("late_sec",  saniye,  0);
      edges(1);
      chk("late_tick", tick_1s, 1);
      chk("late_sec1", saniye,  1);

      // Bouncing press, then steady high.
      btn_raw = 1'b1; edges(2);
      btn_raw = 1'b0; edges(2);
      chk("bnc_clean", btn_clean, 0);
      btn_raw = 1'b1; edges(2);
      btn_raw = 1'b0; edges(2);
      chk("bnc_req",   ped_req,   0);
      btn_raw = 1'b1;
      edges(5);
      chk("deb5_clean", btn_clean, 0);
      chk("deb5_req",   ped_req,   0);
      edges(1);
      chk("deb6_clean", btn_clean, 1);
      chk("deb6_req",   ped_req,   0);
      edges(1);
      chk("req_set",    ped_req,   1);

      // Single ack pulse clears the request.
      req_ack = 1'b1;
      edges(1);
      chk("ack_clr",  ped_req, 0);
      req_ack = 1'b0;
      edges(1);
      chk("ack_hold", ped_req, 0);

      // Release, re-press, ack coincident with the new set edge.
      btn_raw = 1'b0;
      edges(6);
      chk("rel_clean", btn_clean, 0);
      btn_raw = 1'b1;
      edges(6);
      chk("rep_clean", btn_clean, 1);
      req_ack = 1'b1;
      edges(1);
      chk("set_wins",  ped_req, 1);
      edges(1);
      chk("ack_level", ped_req, 0);
      req_ack = 1'b0;

      // Align with sync_clr, count to 37, then reset between edges.
      sync_clr = 1'b1;
      edges(1);
      chk("clr_sec",  saniye,  0);
      chk("clr_tick", tick_1s, 0);
      sync_clr = 1'b0;
      edges(372);
      chk("sec37",    saniye,  37);
      #2;
      reset   = 1'b0;
      btn_raw = 1'b0;
      #1;
      chk("ar_sec",   saniye,      0);
      chk("ar_tick",  tick_1s,     0);
      chk("ar_wrap",  minute_wrap, 0);
      chk("ar_clean", btn_clean,   0);
      chk("ar_req",   ped_req,     0);
      @(posedge clk); #1;
      reset = 1'b1;
      edges(9);
      chk("ar_pre9",  tick_1s, 0);
      edges(1);
      chk("ar_tick1", tick_1s, 1);
      chk("ar_sec1",  saniye,  1);

      // sync_clr on the terminal-count cycle suppresses the tick.
      edges(9);
      sync_clr = 1'b1;
      edges(1);
      chk("sc_tick",  tick_1s,     0);
      chk("sc_sec",   saniye,      0);
      chk("sc_wrap",  minute_wrap, 0);
      sync_clr = 1'b0;
      edges(9);
      chk("sc_pre9",  tick_1s, 0);
      edges(1);
      chk("sc_tick1", tick_1s, 1);
      chk("sc_sec1",  saniye,  1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
